fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit Redux-V core. It owns the program counter, drives the combinational-read instruction memory address, and latches the returned byte into a fetch/decode register. The register is presented to the decoder with a valid/ready handshake. The stage supports redirect (branch/jump) with flush, sticky halt, and a saturating retired-fetch counter.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 8-bit Redux-V core: program counter, fetch/decode
// register with valid/ready handoff, redirect/flush, sticky halt, saturating fetch counter.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [1:0] ST_START  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0] state;
    logic       accept;
    logic       load_ok;
    logic       fetch_en;
    logic       flush;
    logic       go_halt;

    assign accept    = ir_valid & ir_ready;
    assign load_ok   = !ir_valid | ir_ready;
    assign imem_addr = pc;
    assign halted    = (state == ST_HALTED);

    // Only RUN reacts to redirect/halt; redirect wins over halt, halt wins over fetch.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fetch_en = 1'b0;
        flush    = 1'b0;
        go_halt  = 1'b0;
        if (state == ST_RUN) begin
            if (redirect_valid) begin
                flush   = 1'b1;
                go_halt = halt;
            end else if (halt) begin
                go_halt = 1'b1;
            end else begin
                fetch_en = load_ok;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_START;
            pc          <= RESET_PC;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (accept && (fetch_count != {CNT_W{1'b1}}))
                fetch_count <= fetch_count + CNT_W'(1);

            case (state)
                ST_START: state <= ST_RUN;
                ST_RUN:   if (go_halt) state <= ST_HALTED;
                default:  state <= ST_HALTED;
            endcase

            // A flush drops ir even under backpressure; otherwise ir only empties on accept.
            if (flush) begin
                pc       <= redirect_target;
                ir_valid <= 1'b0;
            end else if (fetch_en) begin
                ir       <= imem_instr;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + ADDR_W'(1);
            end else if (accept) begin
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic, with a
// handshake scoreboard fed by a behavioural model and a negedge monitor.
module tb_fetch_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef enum {P_START, P_RUN, P_HALTED} phase_t;

    logic             clk;
    logic             rst;
    logic [7:0]       imem_addr;
    logic [7:0]       imem_instr;
    logic [7:0]       ir;
    logic [7:0]       ir_pc;
    logic             ir_valid;
    logic             ir_ready;
    logic             redirect_valid;
    logic [7:0]       redirect_target;
    logic             halt;
    logic [7:0]       pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Reference model: what the stage should hold after each edge.
    phase_t     m_phase;
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_irpc;
    logic       m_valid;
    int         m_cnt;

    // Expected handed-off instructions, {ir_pc, ir}, in order.
    logic [15:0] sb_q[$];
    logic [15:0] mon_e;

    function automatic logic [7:0] mem(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    assign imem_instr = mem(imem_addr);

    fetch_unit #(
        .ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .pc(pc), .halted(halted), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_START;
        m_pc    = 8'h00;
        m_ir    = 8'h00;
        m_irpc  = 8'h00;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    // Applies the rules for one rising edge given the inputs held during the cycle.
    task automatic model_edge(input logic rdy, input logic rv, input logic [7:0] tgt, input logic hl);
        logic taken;
        taken = m_valid && rdy;
        if (taken && m_cnt < CNT_MAX) m_cnt++;
        case (m_phase)
            P_START: begin
                m_phase = P_RUN;
                if (taken) m_valid = 1'b0;
            end
            P_RUN: begin
                if (rv) begin
                    m_pc    = tgt;
                    m_valid = 1'b0;
                    if (hl) m_phase = P_HALTED;
                end else if (hl) begin
                    m_phase = P_HALTED;
                    if (taken) m_valid = 1'b0;
                end else if (!m_valid || rdy) begin
                    m_irpc  = m_pc;
                    m_ir    = mem(m_pc);
                    m_valid = 1'b1;
                    m_pc    = m_pc + 8'd1;
                end
            end
            default: if (taken) m_valid = 1'b0;
        endcase
    endtask

    // Drive one cycle of inputs (called at posedge+1), record any expected handoff, advance model.
    task automatic step(input logic rdy, input logic rv, input logic [7:0] tgt, input logic hl);
        ir_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt            = hl;
        if (m_valid && rdy) sb_q.push_back({m_irpc, m_ir});
        @(posedge clk);
        #1;
        model_edge(rdy, rv, tgt, hl);
    endtask

    // Monitor: per-cycle architectural state plus scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            check("ir_valid", 32'(ir_valid), 32'(m_valid));
            check("halted", 32'(halted), 32'(m_phase == P_HALTED));
            check("fetch_count", 32'(fetch_count), 32'(m_cnt));
            if (ir_valid && ir_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected handshake", 32'(ir_pc), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("handoff ir_pc", 32'(ir_pc), 32'(mon_e[15:8]));
                    check("handoff ir", 32'(ir), 32'(mon_e[7:0]));
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        ir_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        halt            = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", 32'(pc), 32'h0);
        check("reset ir", 32'(ir), 32'h0);
        check("reset ir_pc", 32'(ir_pc), 32'h0);
        check("reset ir_valid", 32'(ir_valid), 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        check("reset fetch_count", 32'(fetch_count), 32'h0);
        rst = 1'b0;

        // Free-running stream from address 0.
        repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Backpressure while ir holds address 4.
        for (int i = 0; i < 20 && !(m_valid && m_irpc == 8'h04); i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Redirect flushes a stalled ir.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0);
        repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);

        // PC wrap from 0xFF to 0x00.
        step(1'b1, 1'b1, 8'hFE, 1'b0);
        repeat (6) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Random backpressure and redirects.
        repeat (300)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 8'($urandom), 1'b0);

        // Asynchronous reset in the middle of a run at pc 0x33.
        step(1'b1, 1'b1, 8'h30, 1'b0);
        for (int i = 0; i < 10 && m_pc != 8'h33; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("pre-reset pc", 32'(pc), 32'h33);
        check("pre-reset ir_valid", 32'(ir_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("async reset pc", 32'(pc), 32'h0);
        check("async reset ir_valid", 32'(ir_valid), 32'h0);
        check("async reset fetch_count", 32'(fetch_count), 32'h0);
        check("async reset ir", 32'(ir), 32'h0);
        check("async reset ir_pc", 32'(ir_pc), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Sticky halt with a pending ir, then ignored redirect and random traffic.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b0);
        repeat (30)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
